// File: rtl/csi_param_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : csi_param_decoder
//  Description : Parser for ANSI CSI escape sequences (ESC '[' params final).
//                Accumulates up to NPARAM decimal parameters of PW bits each
//                (saturating) and emits one registered command record per
//                completed sequence. Malformed sequences produce a one-cycle
//                seq_err_o pulse and leave the last command record untouched.
//  Config      : define CSI_PRIVATE_EN to accept a leading '?' after '['
//                and expose cmd_private_o.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                in_i, in_valid_i  - byte stream, consumed when valid
//                cmd_valid_o       - one-cycle pulse, new record valid
//                cmd_code_o        - final byte of the sequence
//                cmd_nparam_o      - number of parameter fields stored
//                cmd_params_o      - param i at [i*PW +: PW]
//                cmd_overflow_o    - saturation or too many fields
//                cmd_private_o     - '?' prefix seen (CSI_PRIVATE_EN only)
//                seq_err_o         - one-cycle pulse, sequence aborted
//                busy_o            - parser is inside a sequence
//  Revision    : 1.0 - initial release
// ============================================================================
module csi_param_decoder #(
    parameter int NPARAM = 2,
    parameter int PW     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   in_i,
    input  logic                         in_valid_i,
    output logic                         cmd_valid_o,
    output logic [7:0]                   cmd_code_o,
    output logic [$clog2(NPARAM+1)-1:0]  cmd_nparam_o,
    output logic [NPARAM*PW-1:0]         cmd_params_o,
    output logic                         cmd_overflow_o,
`ifdef CSI_PRIVATE_EN
    output logic                         cmd_private_o,
`endif
    output logic                         seq_err_o,
    output logic                         busy_o
);

    localparam int IW = $clog2(NPARAM + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ESC   = 2'd1,
        S_PARAM = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          acc_q [NPARAM];
    logic [PW-1:0]          acc_d [NPARAM];
    logic [IW-1:0]          idx_q, idx_d;
    logic                   seen_q, seen_d;     // any digit or ';' in this sequence
    logic                   ovf_q, ovf_d;

    logic                   cmd_valid_q, cmd_valid_d;
    logic [7:0]             cmd_code_q, cmd_code_d;
    logic [IW-1:0]          cmd_nparam_q, cmd_nparam_d;
    logic [NPARAM*PW-1:0]   cmd_params_q, cmd_params_d;
    logic                   cmd_ovf_q, cmd_ovf_d;
    logic                   seq_err_q, seq_err_d;
`ifdef CSI_PRIVATE_EN
    logic                   first_q, first_d;   // next PARAM byte is the first after '['
    logic                   priv_q, priv_d;
    logic                   cmd_priv_q, cmd_priv_d;
`endif

    // Byte classification
    logic w_is_digit, w_is_semi, w_is_final, w_is_esc;
    assign w_is_digit = (in_i >= 8'h30) && (in_i <= 8'h39);
    assign w_is_semi  = (in_i == 8'h3B);
    assign w_is_final = (in_i >= 8'h40) && (in_i <= 8'h7E);
    assign w_is_esc   = (in_i == 8'h1B);

    // acc*10 + digit, done as shifts at PW+4 bits; the result cannot exceed
    // 10*(2**PW-1)+9 < 2**(PW+4), so any set upper bit means saturation.
    logic [PW-1:0]   w_cur;
    logic [PW+3:0]   w_mul;
    logic            w_sat;
    logic [PW-1:0]   w_newval;

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < NPARAM; i++) begin
            if (idx_q == IW'(i)) begin
                w_cur = acc_q[i];
            end
        end
    end

    assign w_mul    = ({4'b0000, w_cur} << 3) + ({4'b0000, w_cur} << 1)
                    + {{PW{1'b0}}, in_i[3:0]};
    assign w_sat    = |w_mul[PW+3:PW];
    assign w_newval = w_sat ? {PW{1'b1}} : w_mul[PW-1:0];

    // Sequential state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < NPARAM; i++) begin
                acc_q[i] <= '0;
            end
            idx_q        <= '0;
            seen_q       <= 1'b0;
            ovf_q        <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= '0;
            cmd_nparam_q <= '0;
            cmd_params_q <= '0;
            cmd_ovf_q    <= 1'b0;
            seq_err_q    <= 1'b0;
`ifdef CSI_PRIVATE_EN
            first_q      <= 1'b0;
            priv_q       <= 1'b0;
            cmd_priv_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < NPARAM; i++) begin
                acc_q[i] <= acc_d[i];
            end
            idx_q        <= idx_d;
            seen_q       <= seen_d;
            ovf_q        <= ovf_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            cmd_nparam_q <= cmd_nparam_d;
            cmd_params_q <= cmd_params_d;
            cmd_ovf_q    <= cmd_ovf_d;
            seq_err_q    <= seq_err_d;
`ifdef CSI_PRIVATE_EN
            first_q      <= first_d;
            priv_q       <= priv_d;
            cmd_priv_q   <= cmd_priv_d;
`endif
        end
    end

    // Next-state and record logic
    always_comb begin
        state_d      = state_q;
        for (int i = 0; i < NPARAM; i++) begin
            acc_d[i] = acc_q[i];
        end
        idx_d        = idx_q;
        seen_d       = seen_q;
        ovf_d        = ovf_q;
        cmd_valid_d  = 1'b0;
        cmd_code_d   = cmd_code_q;
        cmd_nparam_d = cmd_nparam_q;
        cmd_params_d = cmd_params_q;
        cmd_ovf_d    = cmd_ovf_q;
        seq_err_d    = 1'b0;
`ifdef CSI_PRIVATE_EN
        first_d      = first_q;
        priv_d       = priv_q;
        cmd_priv_d   = cmd_priv_q;
`endif

        if (in_valid_i) begin
            case (state_q)
                S_IDLE: begin
                    if (w_is_esc) begin
                        state_d = S_ESC;
                    end
                end

                S_ESC: begin
                    if (in_i == 8'h5B) begin
                        state_d = S_PARAM;
                        for (int i = 0; i < NPARAM; i++) begin
                            acc_d[i] = '0;
                        end
                        idx_d   = '0;
                        seen_d  = 1'b0;
                        ovf_d   = 1'b0;
`ifdef CSI_PRIVATE_EN
                        first_d = 1'b1;
                        priv_d  = 1'b0;
`endif
                    end else if (!w_is_esc) begin
                        state_d   = S_IDLE;
                        seq_err_d = 1'b1;
                    end
                end

                S_PARAM: begin
`ifdef CSI_PRIVATE_EN
                    first_d = 1'b0;
`endif
                    if (w_is_digit) begin
                        seen_d = 1'b1;
                        // Fields beyond NPARAM are silently dropped
                        if (idx_q < IW'(NPARAM)) begin
                            for (int i = 0; i < NPARAM; i++) begin
                                if (idx_q == IW'(i)) begin
                                    acc_d[i] = w_newval;
                                end
                            end
                            if (w_sat) begin
                                ovf_d = 1'b1;
                            end
                        end
                    end else if (w_is_semi) begin
                        seen_d = 1'b1;
                        // idx parks at NPARAM once the field budget is exhausted
                        if (idx_q < IW'(NPARAM - 1)) begin
                            idx_d = idx_q + 1'b1;
                        end else begin
                            idx_d = IW'(NPARAM);
                            ovf_d = 1'b1;
                        end
                    end else if (w_is_final) begin
                        state_d     = S_IDLE;
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = in_i;
                        cmd_ovf_d   = ovf_q;
                        for (int i = 0; i < NPARAM; i++) begin
                            cmd_params_d[i*PW +: PW] = acc_q[i];
                        end
                        if (!seen_q) begin
                            cmd_nparam_d = '0;
                        end else if (idx_q >= IW'(NPARAM)) begin
                            cmd_nparam_d = IW'(NPARAM);
                        end else begin
                            cmd_nparam_d = idx_q + 1'b1;
                        end
`ifdef CSI_PRIVATE_EN
                        cmd_priv_d  = priv_q;
`endif
                    end else if (w_is_esc) begin
                        state_d   = S_ESC;
                        seq_err_d = 1'b1;
`ifdef CSI_PRIVATE_EN
                    end else if ((in_i == 8'h3F) && first_q) begin
                        priv_d    = 1'b1;
`endif
                    end else begin
                        state_d   = S_IDLE;
                        seq_err_d = 1'b1;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign cmd_valid_o    = cmd_valid_q;
    assign cmd_code_o     = cmd_code_q;
    assign cmd_nparam_o   = cmd_nparam_q;
    assign cmd_params_o   = cmd_params_q;
    assign cmd_overflow_o = cmd_ovf_q;
    assign seq_err_o      = seq_err_q;
    assign busy_o         = (state_q != S_IDLE);
`ifdef CSI_PRIVATE_EN
    assign cmd_private_o  = cmd_priv_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csi_param_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csi_param_decoder
//  Description : Directed self-checking bench for csi_param_decoder with
//                NPARAM=2, PW=8. Each task drives one scenario and checks
//                the command record against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csi_param_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  in_i;
    logic        in_valid_i;
    logic        cmd_valid_o;
    logic [7:0]  cmd_code_o;
    logic [1:0]  cmd_nparam_o;
    logic [15:0] cmd_params_o;
    logic        cmd_overflow_o;
`ifdef CSI_PRIVATE_EN
    logic        cmd_private_o;
`endif
    logic        seq_err_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int vcount   = 0;
    int ecount   = 0;

    csi_param_decoder #(.NPARAM(2), .PW(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_i           (in_i),
        .in_valid_i     (in_valid_i),
        .cmd_valid_o    (cmd_valid_o),
        .cmd_code_o     (cmd_code_o),
        .cmd_nparam_o   (cmd_nparam_o),
        .cmd_params_o   (cmd_params_o),
        .cmd_overflow_o (cmd_overflow_o),
`ifdef CSI_PRIVATE_EN
        .cmd_private_o  (cmd_private_o),
`endif
        .seq_err_o      (seq_err_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge
    always @(negedge clk) begin
        if (cmd_valid_o) vcount++;
        if (seq_err_o)   ecount++;
    end

    // Drive one byte for one clock; return 1ns after the consuming edge,
    // then optionally idle for gap cycles.
    task automatic send(input logic [7:0] b, input int gap);
        in_i       = b;
        in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        in_i       = 8'h00;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_rec(input string name, input logic [7:0] code,
                           input logic [1:0] np, input logic [15:0] prm,
                           input logic ovf);
        n_checks++;
        if (cmd_code_o !== code || cmd_nparam_o !== np ||
            cmd_params_o !== prm || cmd_overflow_o !== ovf) begin
            n_fail++;
            $display("FAIL %s: got code=%h np=%0d params=%h ovf=%b, expected code=%h np=%0d params=%h ovf=%b",
                     name, cmd_code_o, cmd_nparam_o, cmd_params_o, cmd_overflow_o,
                     code, np, prm, ovf);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        in_valid_i = 1'b0;
        in_i       = 8'h00;
        idle(3);
        rst = 1'b0;
        idle(1);
        n_checks++;
        if (cmd_valid_o !== 1'b0 || seq_err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got valid=%b err=%b busy=%b, expected 0 0 0",
                     cmd_valid_o, seq_err_o, busy_o);
        end
        chk_rec("reset_record", 8'h00, 2'd0, 16'h0000, 1'b0);
    endtask

    task automatic test_basic();
        int v0;
        v0 = vcount;
        send(8'h1B, 0);
        n_checks++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b expected 1", busy_o);
        end
        send(8'h5B, 0); send(8'h31, 0); send(8'h32, 0); send(8'h3B, 0);
        send(8'h33, 0); send(8'h34, 0);
        n_checks++;
        if (cmd_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_early_valid: got %b expected 0", cmd_valid_o);
        end
        send(8'h48, 0);
        n_checks++;
        if (cmd_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: got valid=%b expected 1", cmd_valid_o);
        end
        chk_rec("basic_12_34_H", 8'h48, 2'd2, 16'h220C, 1'b0);
        idle(1);
        n_checks++;
        if (cmd_valid_o !== 1'b0 || busy_o !== 1'b0 || vcount - v0 != 1) begin
            n_fail++;
            $display("FAIL basic_pulse: got valid=%b busy=%b pulses=%0d, expected 0 0 1",
                     cmd_valid_o, busy_o, vcount - v0);
        end
    endtask

    task automatic test_forms();
        // ESC [ 3 ~
        send(8'h1B, 0); send(8'h5B, 0); send(8'h33, 0); send(8'h7E, 0);
        chk_rec("form_3_tilde", 8'h7E, 2'd1, 16'h0003, 1'b0);
        // back-to-back: ESC right after the final byte; ESC [ C
        send(8'h1B, 0); send(8'h5B, 0); send(8'h43, 0);
        chk_rec("form_empty_C", 8'h43, 2'd0, 16'h0000, 1'b0);
        // ESC [ ; 5 H
        send(8'h1B, 0); send(8'h5B, 0); send(8'h3B, 0); send(8'h35, 0); send(8'h48, 0);
        chk_rec("form_semi_5_H", 8'h48, 2'd2, 16'h0500, 1'b0);
        // repeated ESC stays in ESC: ESC ESC [ 4 A
        send(8'h1B, 0); send(8'h1B, 0); send(8'h5B, 0); send(8'h34, 0); send(8'h41, 0);
        chk_rec("form_double_esc", 8'h41, 2'd1, 16'h0004, 1'b0);
        idle(1);
    endtask

    task automatic test_overflow();
        // ESC [ 3 0 0 D -> saturates at 255
        send(8'h1B, 0); send(8'h5B, 0); send(8'h33, 0); send(8'h30, 0);
        send(8'h30, 0); send(8'h44, 0);
        chk_rec("ovf_saturate", 8'h44, 2'd1, 16'h00FF, 1'b1);
        // ESC [ 2 5 5 D -> exactly max, no overflow
        send(8'h1B, 0); send(8'h5B, 0); send(8'h32, 0); send(8'h35, 0);
        send(8'h35, 0); send(8'h44, 0);
        chk_rec("ovf_exact_max", 8'h44, 2'd1, 16'h00FF, 1'b0);
        // ESC [ 1 ; 2 ; 3 m -> third field dropped
        send(8'h1B, 0); send(8'h5B, 0); send(8'h31, 0); send(8'h3B, 0);
        send(8'h32, 0); send(8'h3B, 0); send(8'h33, 0); send(8'h6D, 0);
        chk_rec("ovf_fields", 8'h6D, 2'd2, 16'h0201, 1'b1);
        // ESC [ 7 m -> flags cleared for the new sequence
        send(8'h1B, 0); send(8'h5B, 0); send(8'h37, 0); send(8'h6D, 0);
        chk_rec("ovf_cleared", 8'h6D, 2'd1, 16'h0007, 1'b0);
        idle(1);
    endtask

    task automatic test_abort();
        int v0;
        int e0;
        v0 = vcount;
        e0 = ecount;
        // ESC [ 1 ESC [ 5 B
        send(8'h1B, 0); send(8'h5B, 0); send(8'h31, 0); send(8'h1B, 0);
        n_checks++;
        if (seq_err_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_esc_err: got err=%b busy=%b expected 1 1", seq_err_o, busy_o);
        end
        send(8'h5B, 0);
        n_checks++;
        if (seq_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_err_width: got %b expected 0", seq_err_o);
        end
        send(8'h35, 0); send(8'h42, 0);
        chk_rec("abort_restart_B", 8'h42, 2'd1, 16'h0005, 1'b0);
        // ESC [ 1 LF -> abort, record unchanged
        send(8'h1B, 0); send(8'h5B, 0); send(8'h31, 0); send(8'h0A, 0);
        n_checks++;
        if (seq_err_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_ctrl_err: got err=%b busy=%b expected 1 0", seq_err_o, busy_o);
        end
        chk_rec("abort_keeps_record", 8'h42, 2'd1, 16'h0005, 1'b0);
        // ESC X -> abort from ESC state
        send(8'h1B, 0); send(8'h58, 0);
        n_checks++;
        if (seq_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_esc_other: got %b expected 1", seq_err_o);
        end
        idle(2);
        n_checks++;
        if (vcount - v0 != 1 || ecount - e0 != 3) begin
            n_fail++;
            $display("FAIL abort_counts: got valid=%0d err=%0d expected 1 3",
                     vcount - v0, ecount - e0);
        end
    endtask

    task automatic test_gaps_and_reset();
        logic [7:0] seq [8];
        int v0;
        seq = '{8'h1B, 8'h5B, 8'h31, 8'h32, 8'h3B, 8'h33, 8'h34, 8'h48};
        v0 = vcount;
        for (int i = 0; i < 8; i++) begin
            send(seq[i], i % 4);
        end
        idle(1);
        chk_rec("gaps_record", 8'h48, 2'd2, 16'h220C, 1'b0);
        n_checks++;
        if (vcount - v0 != 1) begin
            n_fail++;
            $display("FAIL gaps_pulses: got %0d expected 1", vcount - v0);
        end
        // reset mid-sequence after ESC [ 7
        send(8'h1B, 0); send(8'h5B, 0); send(8'h37, 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0 || cmd_valid_o !== 1'b0 || seq_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_flags: got busy=%b valid=%b err=%b expected 0 0 0",
                     busy_o, cmd_valid_o, seq_err_o);
        end
        chk_rec("midreset_record", 8'h00, 2'd0, 16'h0000, 1'b0);
        send(8'h1B, 0); send(8'h5B, 0); send(8'h32, 0); send(8'h4A, 0);
        chk_rec("after_reset_J", 8'h4A, 2'd1, 16'h0002, 1'b0);
        idle(1);
    endtask

    task automatic test_private();
        int v0;
        int e0;
        v0 = vcount;
        e0 = ecount;
        send(8'h1B, 0); send(8'h5B, 0); send(8'h3F, 0); send(8'h32, 0);
        send(8'h35, 0); send(8'h68, 0);
`ifdef CSI_PRIVATE_EN
        chk_rec("private_25h", 8'h68, 2'd1, 16'h0019, 1'b0);
        n_checks++;
        if (cmd_private_o !== 1'b1 || vcount - v0 != 0 || ecount != e0) begin
            n_fail++;
            $display("FAIL private_flag: got priv=%b err=%0d expected 1 0",
                     cmd_private_o, ecount - e0);
        end
        // '?' not in first position aborts
        send(8'h1B, 0); send(8'h5B, 0); send(8'h31, 0); send(8'h3F, 0);
        n_checks++;
        if (seq_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL private_late_q: got %b expected 1", seq_err_o);
        end
        send(8'h1B, 0); send(8'h5B, 0); send(8'h31, 0); send(8'h68, 0);
        n_checks++;
        if (cmd_private_o !== 1'b0) begin
            n_fail++;
            $display("FAIL private_cleared: got %b expected 0", cmd_private_o);
        end
`else
        idle(2);
        n_checks++;
        if (vcount - v0 != 0 || ecount - e0 != 1) begin
            n_fail++;
            $display("FAIL private_rejected: got valid=%0d err=%0d expected 0 1",
                     vcount - v0, ecount - e0);
        end
        chk_rec("private_keeps_record", 8'h4A, 2'd1, 16'h0002, 1'b0);
`endif
        idle(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forms();
        test_overflow();
        test_abort();
        test_gaps_and_reset();
        test_private();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
